// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Multi-cycle LSR/LSL/ASR/ROR sequencer, one bit per clock,
//               amount taken from rfread[AMT_BITS-1:0]. Define SHIFT_CARRY_EN
//               to add the carry output (last bit shifted out).
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
    parameter int WIDTH    = 16,
    parameter int AMT_BITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] rfread,
    output logic             busy,
    output logic             done,
`ifdef SHIFT_CARRY_EN
    output logic             carry,
`endif
    output logic [WIDTH-1:0] out
);

    localparam logic [1:0]          c_op_lsr   = 2'b00;
    localparam logic [1:0]          c_op_lsl   = 2'b01;
    localparam logic [1:0]          c_op_asr   = 2'b10;
    localparam logic [AMT_BITS-1:0] c_amt_zero = '0;
    localparam logic [AMT_BITS-1:0] c_amt_one  = AMT_BITS'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    state_t              w_start_target;
    logic                w_accept;
    logic [1:0]          r_op;
    logic [AMT_BITS-1:0] r_count;
    logic [AMT_BITS-1:0] w_amt;
    logic [WIDTH-1:0]    w_step;
    logic                w_unused_rfread;

    assign w_amt           = rfread[AMT_BITS-1:0];
    assign w_unused_rfread = ^rfread[WIDTH-1:AMT_BITS];
    assign w_start_target  = (w_amt == c_amt_zero) ? S_DONE : S_SHIFT;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = w_start_target;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (r_count == c_amt_one) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                // A start here chains the next op without an idle bubble
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = w_start_target;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_step = out;
        case (r_op)
            c_op_lsr: w_step = {1'b0, out[WIDTH-1:1]};
            c_op_lsl: w_step = {out[WIDTH-2:0], 1'b0};
            c_op_asr: w_step = {out[WIDTH-1], out[WIDTH-1:1]};
            default:  w_step = {out[0], out[WIDTH-1:1]};
        endcase
    end

    // out doubles as the working register, so partial results are visible
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out     <= '0;
            r_op    <= 2'b00;
            r_count <= '0;
        end else if (w_accept) begin
            out     <= in;
            r_op    <= op;
            r_count <= w_amt;
        end else if (r_state == S_SHIFT) begin
            out     <= w_step;
            r_count <= r_count - c_amt_one;
        end
    end

`ifdef SHIFT_CARRY_EN
    logic w_shout;

    assign w_shout = (r_op == c_op_lsl) ? out[WIDTH-1] : out[0];

    // Only shift edges touch carry, so a zero-amount op leaves it as it was
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry <= 1'b0;
        end else if (r_state == S_SHIFT) begin
            carry <= w_shout;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// Scoreboard bench for shift_sequencer: directed ops push expected results,
// a negedge monitor pops and checks them whenever done is seen.
module tb_shift_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] in;
    logic [W-1:0] rfread;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
`ifdef SHIFT_CARRY_EN
    logic         carry;
`endif

    typedef struct {
        logic [W-1:0] out;
        logic         c;
        int           cyc;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_done = 0;

    shift_sequencer #(.WIDTH(W), .AMT_BITS(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .in     (in),
        .rfread (rfread),
        .busy   (busy),
        .done   (done),
`ifdef SHIFT_CARRY_EN
        .carry  (carry),
`endif
        .out    (out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && done) begin
            n_done++;
            chk("busy_with_done", 32'(busy), 32'(0));
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: out=%h with no pending op", out);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_out"}, 32'(out), 32'(e.out));
                chk({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
`ifdef SHIFT_CARRY_EN
                chk({e.name, "_carry"}, 32'(carry), 32'(e.c));
`endif
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] rf, input logic [W-1:0] eo,
                            input logic ec, input string nm);
        sb.push_back(exp_t'{eo, ec, cyc + 1 + int'(rf[3:0]), nm});
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] d, input logic [W-1:0] rf,
                         input logic [W-1:0] eo, input logic ec, input string nm);
        @(negedge clk);
        op     = o;
        in     = d;
        rfread = rf;
        start  = 1'b1;
        push_exp(rf, eo, ec, nm);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: %0d ops still pending", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int snap;
        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        in     = '0;
        rfread = '0;
        #1;
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_done", 32'(done), 32'(0));
        chk("reset_out",  32'(out),  32'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;

        issue(2'b00, 16'hF0F0, 16'h0004, 16'h0F0F, 1'b0, "lsr_f0f0"); drain();
        issue(2'b10, 16'h8001, 16'h0001, 16'hC000, 1'b1, "asr_8001"); drain();
        issue(2'b00, 16'h1234, 16'hFFF0, 16'h1234, 1'b1, "zero_amt"); drain();
        issue(2'b11, 16'h8001, 16'h0001, 16'hC000, 1'b1, "ror_8001"); drain();
        issue(2'b11, 16'h0001, 16'h000F, 16'h0002, 1'b0, "ror_max");  drain();
        issue(2'b01, 16'h0001, 16'h0013, 16'h0008, 1'b0, "lsl_mask"); drain();
        issue(2'b01, 16'h8000, 16'h0001, 16'h0000, 1'b1, "lsl_8000"); drain();
        issue(2'b00, 16'hFFFF, 16'h000F, 16'h0001, 1'b1, "lsr_max");  drain();

        // start pulsed mid-shift with different operands must be ignored
        issue(2'b00, 16'h00F0, 16'h0004, 16'h000F, 1'b0, "ignore");
        op = 2'b01; in = 16'hFFFF; rfread = 16'h0001; start = 1'b1;
        @(negedge clk);
        chk("ignore_busy", 32'(busy), 32'(1));
        start = 1'b0;
        drain();

        // start held across DONE chains the second op immediately
        @(negedge clk);
        op = 2'b01; in = 16'h0003; rfread = 16'h0002; start = 1'b1;
        push_exp(16'h0002, 16'h000C, 1'b0, "b2b_first");
        @(negedge clk);
        op = 2'b11; in = 16'h0003; rfread = 16'h0001;
        sb.push_back(exp_t'{16'h8001, 1'b1, cyc + 4, "b2b_second"});
        repeat (3) @(negedge clk);
        start = 1'b0;
        drain();

        // async reset in the middle of a 10-step shift
        issue(2'b01, 16'h0001, 16'h000A, 16'h0400, 1'b0, "aborted");
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'(1));
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_busy", 32'(busy), 32'(0));
        chk("async_done", 32'(done), 32'(0));
        chk("async_out",  32'(out),  32'(0));
`ifdef SHIFT_CARRY_EN
        chk("async_carry", 32'(carry), 32'(0));
`endif
        sb.delete();
        snap = n_done;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("no_done_after_reset", 32'(n_done - snap), 32'(0));

        issue(2'b10, 16'h8000, 16'h0004, 16'hF800, 1'b0, "post_reset_asr"); drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
